pc_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the core's program-count register and drives the instruction-memory request port. It generates the sequential PC+4 stream, applies branch/jump redirects from execute, honours decode back-pressure, and keeps the memory handshake legal when a redirect lands mid-request. It sits between the PC datapath, instruction memory and the decode stage, and presents each fetched instruction with its PC and PC+4.

---
 rtl/pc_fetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction-fetch sequencer.
// Owns the program counter, issues instruction-memory requests, applies
// execute-stage redirects and honours decode back-pressure. A redirect that
// lands while a request is waiting for its acknowledge is parked in
// pending_pc until the memory completes the request. This keeps the request
// port stable.
//
// Optional feature: define PC_MISALIGN_TRAP_EN to reject redirect targets
// with non-zero bits [1:0]. A rejected redirect pulses Misalign_Fault and
// parks the sequencer in FAULT until an aligned redirect arrives. In the
// default build the low target bits are forced to zero, and Misalign_Fault
// stays low.
module pc_fetch_ctrl #(
  parameter int unsigned       DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  input  logic              Redirect_Valid,
  input  logic [DWIDTH-1:0] Redirect_Addr,
  input  logic              Stall,
  output logic              Imem_Req,
  output logic [DWIDTH-1:0] Imem_Addr,
  input  logic              Imem_Ack,
  input  logic [DWIDTH-1:0] Imem_Rdata,
  output logic              Instr_Valid,
  output logic [DWIDTH-1:0] Instr_Data,
  output logic [DWIDTH-1:0] Instr_PC,
  output logic [DWIDTH-1:0] Instr_PC_Off,
  output logic              Misalign_Fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(4);

  logic [1:0]        state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] pending_pc_q, pending_pc_d;
  logic              pending_bad_q, pending_bad_d;
  logic              valid_q, valid_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [DWIDTH-1:0] ipc_q, ipc_d;
  logic [DWIDTH-1:0] ipc_off_q, ipc_off_d;
  logic              fault_q, fault_d;

  logic              imem_req;
  logic              handshake;
  logic [DWIDTH-1:0] pc_plus4;
  logic [DWIDTH-1:0] redir_addr;
  logic              redir_bad;

`ifdef PC_MISALIGN_TRAP_EN
  assign redir_addr = Redirect_Addr;
  assign redir_bad  = Redirect_Valid && (Redirect_Addr[1:0] != 2'b00);
`else
  // Targets are word aligned by construction; the low bits are ignored.
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^Redirect_Addr[1:0];
  assign redir_addr       = {Redirect_Addr[DWIDTH-1:2], 2'b00};
  assign redir_bad        = 1'b0;
`endif

  // Sequential address wraps modulo 2^DWIDTH with no flag.
  assign pc_plus4  = pc_q + PC_STEP;
  assign handshake = imem_req && Imem_Ack;

  // Request generation: FETCH asks whenever decode can take a new word,
  // DRAIN holds the outstanding request until it is acknowledged.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      S_FETCH: imem_req = !valid_q || !Stall;
      S_DRAIN: imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // Next-state logic: sequencing, redirects and output-register updates.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    pending_bad_d = pending_bad_q;
    valid_d       = valid_q;
    data_d        = data_q;
    ipc_d         = ipc_q;
    ipc_off_d     = ipc_off_q;
    fault_d       = redir_bad;

    case (state_q)
      S_DRAIN: begin
        valid_d = 1'b0;
        // Newest redirect wins, including one arriving with the acknowledge.
        if (Redirect_Valid) begin
          pending_pc_d  = redir_addr;
          pending_bad_d = redir_bad;
        end
        if (Imem_Ack) begin
          pending_bad_d = 1'b0;
          if (Redirect_Valid ? redir_bad : pending_bad_q) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = Redirect_Valid ? redir_addr : pending_pc_q;
            state_d = S_FETCH;
          end
        end
      end
      S_FAULT: begin
        if (Redirect_Valid && !redir_bad) begin
          pc_d    = redir_addr;
          state_d = S_FETCH;
        end
      end
      default: begin
        // IDLE falls through to FETCH after one cycle; it never requests.
        state_d = S_FETCH;
        if (Redirect_Valid) begin
          valid_d = 1'b0;
          if (imem_req && !Imem_Ack) begin
            pending_pc_d  = redir_addr;
            pending_bad_d = redir_bad;
            state_d       = S_DRAIN;
          end else if (redir_bad) begin
            state_d = S_FAULT;
          end else begin
            pc_d = redir_addr;
          end
        end else if (handshake) begin
          valid_d   = 1'b1;
          data_d    = Imem_Rdata;
          ipc_d     = pc_q;
          ipc_off_d = pc_plus4;
          pc_d      = pc_plus4;
        end else if (valid_q && !Stall) begin
          valid_d = 1'b0;
        end
      end
    endcase
  end

  // State registers; reset abandons any outstanding request.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      pending_pc_q  <= RESET_VECTOR;
      pending_bad_q <= 1'b0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      ipc_q         <= '0;
      ipc_off_q     <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_pc_q  <= pending_pc_d;
      pending_bad_q <= pending_bad_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      ipc_q         <= ipc_d;
      ipc_off_q     <= ipc_off_d;
      fault_q       <= fault_d;
    end
  end

  // pc is not advanced while a request is outstanding, so it is the address.
  assign Imem_Req       = imem_req;
  assign Imem_Addr      = pc_q;
  assign Instr_Valid    = valid_q;
  assign Instr_Data     = data_q;
  assign Instr_PC       = ipc_q;
  assign Instr_PC_Off   = ipc_off_q;
  assign Misalign_Fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios with literal expectations,
// followed by a mixed-traffic phase. A transaction-level model is compared
// against the DUT on every falling edge.
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv    = 1'b0;
  logic [31:0] ra    = '0;
  logic        st    = 1'b0;
  logic        ack   = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        iv;
  logic [31:0] idata, ipc, ioff;
  logic        mf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: a simple address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  assign rdata = mem_word(addr);

  pc_fetch_ctrl #(.DWIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .Clk_Core       (clk),
    .Rst_Core_N     (rst_n),
    .Redirect_Valid (rv),
    .Redirect_Addr  (ra),
    .Stall          (st),
    .Imem_Req       (req),
    .Imem_Addr      (addr),
    .Imem_Ack       (ack),
    .Imem_Rdata     (rdata),
    .Instr_Valid    (iv),
    .Instr_Data     (idata),
    .Instr_PC       (ipc),
    .Instr_PC_Off   (ioff),
    .Misalign_Fault (mf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_boot;     // first cycle after reset: no fetch yet
  bit          m_defer;    // redirect waiting for the outstanding request
  bit          m_def_bad;  // deferred target is a rejected (misaligned) one
  bit          m_halt;     // parked after a rejected redirect
  bit          m_fault;    // fault pulse visible this cycle
  logic [31:0] m_pc, m_tgt;
  bit          m_v;
  logic [31:0] m_d, m_ipc, m_ioff;
  bit          p_open;     // last cycle left a request unacknowledged
  logic [31:0] p_addr;

  function automatic void model_reset();
    m_boot = 1; m_defer = 0; m_def_bad = 0; m_halt = 0; m_fault = 0;
    m_pc = 32'h0; m_tgt = 32'h0; m_v = 0;
    m_d = 32'h0; m_ipc = 32'h0; m_ioff = 32'h0;
    p_open = 0; p_addr = 32'h0;
  endfunction

  function automatic bit model_req();
    return !m_boot && (m_defer || (!m_halt && !(m_v && st)));
  endfunction

  function automatic void model_step();
    bit          r, hs, bad;
    logic [31:0] tgt;
    r   = model_req();
    hs  = r && ack;
    bad = TRAP && rv && (ra[1:0] != 2'b00);
    tgt = TRAP ? ra : (ra & 32'hFFFF_FFFC);
    m_fault = bad;
    m_boot  = 0;
    if (m_defer) begin
      if (rv) begin m_tgt = tgt; m_def_bad = bad; end
      if (hs) begin
        m_defer = 0;
        if (m_def_bad) m_halt = 1;
        else m_pc = m_tgt;
      end
    end else if (rv) begin
      m_v = 0;
      if (r && !ack) begin
        m_defer = 1; m_tgt = tgt; m_def_bad = bad;
      end else if (bad) begin
        m_halt = 1;
      end else begin
        m_pc = tgt; m_halt = 0;
      end
    end else if (hs) begin
      m_v = 1; m_d = mem_word(m_pc); m_ipc = m_pc; m_ioff = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
    end else if (m_v && !st) begin
      m_v = 0;
    end
  endfunction

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_req", req, 32'h0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_valid", iv, 32'h0);
      chk("rst_data", idata, 32'h0);
      chk("rst_pc", ipc, 32'h0);
      chk("rst_pcoff", ioff, 32'h0);
      chk("rst_fault", mf, 32'h0);
    end else begin
      chk("m_req", req, model_req());
      if (model_req()) chk("m_addr", addr, m_pc);
      chk("m_valid", iv, m_v);
      if (m_v) begin
        chk("m_data", idata, m_d);
        chk("m_pc", ipc, m_ipc);
        chk("m_pcoff", ioff, m_ioff);
      end
      chk("m_fault", mf, m_fault);
      if (p_open) begin
        chk("hold_req", req, 32'h1);
        chk("hold_addr", addr, p_addr);
      end
      p_open = req && !ack;
      p_addr = addr;
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick(); tick(); tick();
    rst_n = 1'b1; ack = 1'b1;
    mid(); chk("c1_idle_req", req, 32'h0);                      // c1
    tick(); mid(); chk("c2_req", req, 32'h1); chk("c2_addr", addr, 32'h0);
    tick(); mid(); chk("c3_addr", addr, 32'h4); chk("c3_valid", iv, 32'h1);
    chk("c3_pc", ipc, 32'h0); chk("c3_pcoff", ioff, 32'h4);
    chk("c3_data", idata, 32'h0000_FFFF);
    tick(); mid(); chk("c4_addr", addr, 32'h8);
    // decode back-pressure for three cycles
    tick(); st = 1'b1; mid(); chk("c5_req", req, 32'h0); chk("c5_pc", ipc, 32'h8);
    tick(); mid(); chk("c6_pc", ipc, 32'h8);
    tick(); mid(); chk("c7_req", req, 32'h0); chk("c7_pc", ipc, 32'h8);
    tick(); st = 1'b0; mid(); chk("c8_addr", addr, 32'hC); chk("c8_pc", ipc, 32'h8);
    // slow memory with a redirect in the first wait cycle
    tick(); ack = 1'b0; rv = 1'b1; ra = 32'h100;
    mid(); chk("c9_pc", ipc, 32'hC); chk("c9_addr", addr, 32'h10);
    tick(); rv = 1'b0; mid(); chk("c10_addr", addr, 32'h10); chk("c10_valid", iv, 32'h0);
    tick(); tick(); mid(); chk("c12_addr", addr, 32'h10);
    tick(); ack = 1'b1;
    tick(); mid(); chk("c14_addr", addr, 32'h100);
    // two redirects while draining
    tick(); ack = 1'b0; rv = 1'b1; ra = 32'h200;
    mid(); chk("c15_pc", ipc, 32'h100); chk("c15_addr", addr, 32'h104);
    tick(); ra = 32'h300; mid(); chk("c16_addr", addr, 32'h104);
    tick(); rv = 1'b0; ack = 1'b1;
    tick(); mid(); chk("c18_addr", addr, 32'h300);
    // address wrap
    tick(); rv = 1'b1; ra = 32'hFFFF_FFF8; mid(); chk("c19_pc", ipc, 32'h300);
    tick(); rv = 1'b0; mid(); chk("c20_addr", addr, 32'hFFFF_FFF8); chk("c20_valid", iv, 32'h0);
    tick(); mid(); chk("c21_addr", addr, 32'hFFFF_FFFC); chk("c21_pc", ipc, 32'hFFFF_FFF8);
    tick(); mid(); chk("c22_addr", addr, 32'h0); chk("c22_pc", ipc, 32'hFFFF_FFFC);
    chk("c22_pcoff", ioff, 32'h0);
    // redirect together with stall
    tick(); st = 1'b1; rv = 1'b1; ra = 32'h40;
    mid(); chk("c23_valid", iv, 32'h1); chk("c23_req", req, 32'h0);
    tick(); st = 1'b0; rv = 1'b0; mid(); chk("c24_valid", iv, 32'h0); chk("c24_addr", addr, 32'h40);
    // misaligned redirect target
    tick(); rv = 1'b1; ra = 32'h102; mid(); chk("c25_pc", ipc, 32'h40);
    tick(); rv = 1'b0; mid();
`ifdef PC_MISALIGN_TRAP_EN
    chk("c26_fault", mf, 32'h1); chk("c26_req", req, 32'h0);
    tick(); mid(); chk("c27_fault", mf, 32'h0); chk("c27_req", req, 32'h0);
`else
    chk("c26_fault", mf, 32'h0); chk("c26_addr", addr, 32'h100);
    tick(); mid(); chk("c27_pc", ipc, 32'h100);
`endif
    tick(); rv = 1'b1; ra = 32'h200;
    tick(); rv = 1'b0; mid(); chk("c29_req", req, 32'h1); chk("c29_addr", addr, 32'h200);
    tick(); mid(); chk("c30_pc", ipc, 32'h200);
    // misaligned target during a drain, then an aligned recovery
    ack = 1'b0; rv = 1'b1; ra = 32'h303;
    tick(); rv = 1'b0; ack = 1'b1;
    tick();
    tick(); rv = 1'b1; ra = 32'h500;
    tick(); rv = 1'b0;
    tick();
    // redirect arriving in the acknowledge cycle of a drain
    ack = 1'b0; rv = 1'b1; ra = 32'h600;
    tick(); ra = 32'h700; ack = 1'b1;
    tick(); rv = 1'b0; mid(); chk("c37_addr", addr, 32'h700);
    tick();
    // mixed traffic
    for (int i = 0; i < 300; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 7) == 0);
      ra  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFF);
      tick();
    end
    // reset while a request is outstanding
    st = 1'b0; ack = 1'b0; rv = 1'b1; ra = 32'h800;
    tick(); rv = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("ar_req", req, 32'h0); chk("ar_addr", addr, 32'h0);
    chk("ar_valid", iv, 32'h0); chk("ar_fault", mf, 32'h0);
    tick(); tick();
    rst_n = 1'b1; ack = 1'b1;
    tick(); mid(); chk("rr_req", req, 32'h1); chk("rr_addr", addr, 32'h0);
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
